// File: rtl/spi_master_if.sv
// Bundle of the controller-side handshake and the shared SPI bus lines of
// the single-byte SPI master. The master modport is the design's view; the
// slave modport is the view of whoever drives the controller inputs and
// models the SPI slaves.
interface spi_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [1:0]            slaveSelect;
    logic [DATA_WIDTH-1:0] masterDataToSend;
    logic [DATA_WIDTH-1:0] masterDataReceived;
    logic                  SCLK;
    logic [0:2]            CS;
    logic                  MOSI;
    logic                  MISO;

    modport master (
        input  start,
        input  slaveSelect,
        input  masterDataToSend,
        input  MISO,
        output masterDataReceived,
        output SCLK,
        output CS,
        output MOSI
    );

    modport slave (
        output start,
        output slaveSelect,
        output masterDataToSend,
        output MISO,
        input  masterDataReceived,
        input  SCLK,
        input  CS,
        input  MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master (CPOL=0, CPHA=0), one bit per clk.
// A start pulse in IDLE latches the byte and the slave index; the next
// DATA_WIDTH clk cycles shift MOSI out MSB-first while MISO is shifted in.
// The received byte is published on the last edge of the transfer, and the
// FSM is back in IDLE on that same edge so transfers can run back to back.
module spi_master #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_TRANSFER = 1'b1
    } state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] rcv_q;
    logic [0:2]            cs_q;
    logic                  busy_s;

    // One-hot-low chip-select pattern for a slave index; index 3 selects none.
    function automatic logic [0:2] cs_decode(input logic [1:0] sel);
        logic [0:2] cs;
        cs = 3'b111;
        case (sel)
            2'd0:    cs = 3'b011;
            2'd1:    cs = 3'b101;
            2'd2:    cs = 3'b110;
            default: cs = 3'b111;
        endcase
        return cs;
    endfunction

    // Transfer FSM: latch on start, shift both directions, publish and release CS on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rcv_q   <= '0;
            cs_q    <= 3'b111;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        tx_q    <= bus.masterDataToSend;
                        cs_q    <= cs_decode(bus.slaveSelect);
                        cnt_q   <= '0;
                        state_q <= ST_TRANSFER;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TRANSFER: begin
                    rx_q  <= {rx_q[DATA_WIDTH-2:0], bus.MISO};
                    tx_q  <= tx_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        // The final MISO bit is folded in directly, so the
                        // byte is complete on this edge with no extra cycle.
                        rcv_q   <= {rx_q[DATA_WIDTH-2:0], bus.MISO};
                        cs_q    <= 3'b111;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_TRANSFER;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    cs_q    <= 3'b111;
                end
            endcase
        end
    end

    assign busy_s = (state_q == ST_TRANSFER);

    // MOSI follows the shift register MSB so bit 7 appears right after the
    // start edge; SCLK is high in the second half of each busy cycle so the
    // slave samples mid-bit, after MOSI has settled.
    assign bus.MOSI               = busy_s & tx_q[DATA_WIDTH-1];
    assign bus.SCLK               = busy_s & ~clk;
    assign bus.CS                 = cs_q;
    assign bus.masterDataReceived = rcv_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master. A stimulus process starts transfers and
// plays the slave's MISO bits, pushing the expected MOSI byte, CS pattern,
// received byte and start cycle into a scoreboard queue. A monitor pops an
// entry and follows the SCLK pulses the DUT produces, comparing as it goes.
module tb_spi_master;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;
    int   issued = 0;
    int   xfers_done = 0;
    bit   mon_busy = 1'b0;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic [0:2] cs;
        int         nbits;
        bit         abort;
        int         cyc0;
    } exp_t;

    exp_t sbq[$];

    spi_master_if #(.DATA_WIDTH(8)) bus ();

    spi_master #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One transfer: hold keeps start high and perturbs the inputs mid-way,
    // abort_i >= 0 asserts reset during that bit cycle.
    task automatic xfer(input logic [1:0] sel, input logic [7:0] tx, input logic [7:0] rx,
                        input logic [0:2] cs, input bit hold, input int abort_i);
        exp_t e;
        @(negedge clk);
        bus.start            = 1'b1;
        bus.slaveSelect      = sel;
        bus.masterDataToSend = tx;
        e.tx    = tx;
        e.rx    = (abort_i >= 0) ? 8'h00 : rx;
        e.cs    = cs;
        e.nbits = (abort_i >= 0) ? abort_i + 1 : 8;
        e.abort = (abort_i >= 0);
        e.cyc0  = cyc + 1;
        sbq.push_back(e);
        issued++;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == abort_i) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                break;
            end
            bus.MISO = rx[7-i];
            if (hold && i == 3) begin
                bus.masterDataToSend = ~tx;
                bus.slaveSelect      = sel + 2'd1;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.MISO  = 1'b0;
    endtask

    // Monitor: follow each expected transfer through its SCLK pulses.
    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        bit         found;
        forever begin
            while (sbq.size() == 0) @(posedge clk);
            e        = sbq.pop_front();
            mon_busy = 1'b1;
            got      = 8'h00;
            for (int b = 0; b < e.nbits; b++) begin
                found = 1'b0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk); #1;
                    if (bus.SCLK === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (!found) begin
                    check("sclk_timeout", 32'd0, 32'd1);
                    break;
                end
                if (b == 0) check("start_latency", cyc, e.cyc0);
                got = {got[6:0], bus.MOSI};
                check("cs_busy", {29'd0, bus.CS}, {29'd0, e.cs});
            end
            @(posedge clk); #1;
            check("rx_byte", {24'd0, bus.masterDataReceived}, {24'd0, e.rx});
            check("mosi_bits", {24'd0, got}, {24'd0, e.tx >> (8 - e.nbits)});
            if (e.abort) begin
                check("cs_abort", {29'd0, bus.CS}, 32'd7);
                check("mosi_abort", {31'd0, bus.MOSI}, 32'd0);
            end
            @(negedge clk); #1;
            check("sclk_idle", {31'd0, bus.SCLK}, 32'd0);
            check("cs_idle", {29'd0, bus.CS}, 32'd7);
            check("mosi_idle", {31'd0, bus.MOSI}, 32'd0);
            check("rx_hold", {24'd0, bus.masterDataReceived}, {24'd0, e.rx});
            xfers_done++;
            mon_busy = 1'b0;
        end
    end

    // Stimulus sequence.
    initial begin : stimulus
        reset                = 1'b1;
        bus.start            = 1'b0;
        bus.slaveSelect      = 2'd3;
        bus.masterDataToSend = 8'h00;
        bus.MISO             = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_rx", {24'd0, bus.masterDataReceived}, 32'd0);
        check("reset_cs", {29'd0, bus.CS}, 32'd7);
        check("reset_mosi", {31'd0, bus.MOSI}, 32'd0);
        @(negedge clk); #1;
        check("reset_sclk", {31'd0, bus.SCLK}, 32'd0);

        // First data set, back to back across the three slaves.
        xfer(2'd0, 8'b01010011, 8'b00001001, 3'b011, 1'b0, -1);
        xfer(2'd1, 8'b10110010, 8'b00100010, 3'b101, 1'b0, -1);
        xfer(2'd2, 8'b11100001, 8'b10000011, 3'b110, 1'b0, -1);
        // Second data set.
        xfer(2'd0, 8'b00111100, 8'b10011000, 3'b011, 1'b0, -1);
        xfer(2'd1, 8'b00111100, 8'b00100101, 3'b101, 1'b0, -1);
        xfer(2'd2, 8'b00111100, 8'b11000010, 3'b110, 1'b0, -1);
        // No slave selected: transfer still runs and updates the result.
        xfer(2'd3, 8'hC3, 8'h5A, 3'b111, 1'b0, -1);
        // Start held and inputs changed mid-transfer.
        xfer(2'd1, 8'h96, 8'h3B, 3'b101, 1'b1, -1);
        // Reset during bit cycle 4, then a clean transfer.
        xfer(2'd1, 8'hF0, 8'hAA, 3'b101, 1'b0, 4);
        xfer(2'd2, 8'h0F, 8'hE7, 3'b110, 1'b0, -1);

        for (int t = 0; t < 100; t++) begin
            if (sbq.size() == 0 && !mon_busy) break;
            @(posedge clk);
        end
        #2;
        check("xfers_done", xfers_done, issued);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
